// File: rtl/add_sub_pipe_if.sv
`default_nettype none
// ============================================================================
// add_sub_pipe_if : operand/result bus for the pipelined adder-subtractor
// Rev 1.0
// ============================================================================
interface add_sub_pipe_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [1:0]       Op;
   logic             Ci;
   logic             In_valid;
   logic             In_ready;
   logic [WIDTH-1:0] S;
   logic             Co;
   logic             V;
   logic             Z;
   logic             N;
   logic             Out_valid;
   logic             Out_ready;

   modport master (
      output A, B, Op, Ci, In_valid, Out_ready,
      input  In_ready, S, Co, V, Z, N, Out_valid
   );

   modport slave (
      input  A, B, Op, Ci, In_valid, Out_ready,
      output In_ready, S, Co, V, Z, N, Out_valid
   );
endinterface
`default_nettype wire

// File: rtl/add_sub_pipe.sv
`default_nettype none
// ============================================================================
// add_sub_pipe : carry chain split into WIDTH/CHUNK register stages (CHUNK < WIDTH)
// Rev 1.0
// ============================================================================
module add_sub_pipe #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   add_sub_pipe_if.slave bus
);
   localparam int STAGES = WIDTH / CHUNK;
   localparam int MID    = STAGES - 1;
   localparam int L      = STAGES - 1;

   // intermediate stages; the final chunk lands directly in the output registers
   logic             r_vld [MID];
   logic [WIDTH-1:0] r_sum [MID];
   logic [WIDTH-1:0] r_a   [MID];
   logic [WIDTH-1:0] r_b   [MID];
   logic             r_cry [MID];

   logic             r_out_vld;
   logic [WIDTH-1:0] r_s;
   logic             r_co;
   logic             r_v;
   logic             r_z;
   logic             r_n;

   logic [WIDTH-1:0] w_a_in    [STAGES];
   logic [WIDTH-1:0] w_b_in    [STAGES];
   logic [WIDTH-1:0] w_s_in    [STAGES];
   logic [WIDTH-1:0] w_sum_nxt [STAGES];
   logic             w_c_in    [STAGES];
   logic             w_vld_in  [STAGES];
   logic [CHUNK:0]   w_cs      [STAGES];

   logic             w_adv;
   logic [WIDTH-1:0] w_bp;
   logic             w_c0;
   logic [WIDTH-1:0] w_res;
   logic             w_co;
   logic             w_ovf;

   assign w_adv        = bus.Out_ready | ~r_out_vld;
   assign bus.In_ready = w_adv;

   // B is inverted once at entry, so later stages only ever add
   assign w_bp = bus.Op[0] ? ~bus.B : bus.B;
   assign w_c0 = bus.Op[1] ? bus.Ci : bus.Op[0];

   always_comb begin
      w_a_in[0]   = bus.A;
      w_b_in[0]   = w_bp;
      w_s_in[0]   = '0;
      w_c_in[0]   = w_c0;
      w_vld_in[0] = bus.In_valid;
      for (int k = 1; k < STAGES; k++) begin
         w_a_in[k]   = r_a[k-1];
         w_b_in[k]   = r_b[k-1];
         w_s_in[k]   = r_sum[k-1];
         w_c_in[k]   = r_cry[k-1];
         w_vld_in[k] = r_vld[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         w_cs[k] = {1'b0, w_a_in[k][k*CHUNK +: CHUNK]}
                 + {1'b0, w_b_in[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, w_c_in[k]};
         w_sum_nxt[k] = w_s_in[k];
         w_sum_nxt[k][k*CHUNK +: CHUNK] = w_cs[k][CHUNK-1:0];
      end
   end

   assign w_res = w_sum_nxt[L];
   assign w_co  = w_cs[L][CHUNK];
   assign w_ovf = (w_a_in[L][WIDTH-1] == w_b_in[L][WIDTH-1]) &&
                  (w_res[WIDTH-1] != w_a_in[L][WIDTH-1]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < MID; k++) begin
            r_vld[k] <= 1'b0;
            r_sum[k] <= '0;
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_cry[k] <= 1'b0;
         end
         r_out_vld <= 1'b0;
         r_s       <= '0;
         r_co      <= 1'b0;
         r_v       <= 1'b0;
         r_z       <= 1'b0;
         r_n       <= 1'b0;
      end else if (w_adv) begin
         for (int k = 0; k < MID; k++) begin
            r_vld[k] <= w_vld_in[k];
            r_sum[k] <= w_sum_nxt[k];
            r_a[k]   <= w_a_in[k];
            r_b[k]   <= w_b_in[k];
            r_cry[k] <= w_cs[k][CHUNK];
         end
         r_out_vld <= w_vld_in[L];
         // bubbles leave the last result and its flags untouched
         if (w_vld_in[L]) begin
            r_s  <= w_res;
            r_co <= w_co;
            r_v  <= w_ovf;
            r_z  <= (w_res == '0);
            r_n  <= w_res[WIDTH-1];
         end
      end
   end

   assign bus.Out_valid = r_out_vld;
   assign bus.S         = r_s;
   assign bus.Co        = r_co;
   assign bus.V         = r_v;
   assign bus.Z         = r_z;
   assign bus.N         = r_n;
endmodule
`default_nettype wire

// File: tb/tb_add_sub_pipe.sv
`default_nettype none
// ============================================================================
// tb_add_sub_pipe : directed vectors checked against an arithmetic reference
// Rev 1.0
// ============================================================================
module tb_add_sub_pipe;
   localparam int W = 16;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   add_sub_pipe_if #(.WIDTH(W)) bus ();

   add_sub_pipe #(.WIDTH(W), .CHUNK(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_out    = 0;
   logic [19:0] q[$];

   // result packed as {Co, V, Z, N, S}
   function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic [1:0] op, input logic ci);
      logic [15:0] bp;
      logic [16:0] full;
      logic [15:0] s;
      logic        c0;
      logic        v;
      bp = op[0] ? ~b : b;
      case (op)
         2'b00:   c0 = 1'b0;
         2'b01:   c0 = 1'b1;
         default: c0 = ci;
      endcase
      full = {1'b0, a} + {1'b0, bp} + {16'd0, c0};
      s    = full[15:0];
      v    = (a[15] == bp[15]) && (s[15] != a[15]);
      return {full[16], v, (s == 16'h0), s[15], s};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q.delete();
      end else begin
         if (bus.Out_valid && bus.Out_ready && q.size() > 0) begin
            void'(q.pop_front());
            n_out++;
         end
         if (bus.In_valid && bus.In_ready)
            q.push_back(model(bus.A, bus.B, bus.Op, bus.Ci));
      end
   end

   always @(negedge clk) begin
      #1;
      if (!reset_n) begin
         chk("rst_out_valid", {31'd0, bus.Out_valid}, 32'd0);
         chk("rst_outputs", {12'd0, bus.Co, bus.V, bus.Z, bus.N, bus.S}, 32'd0);
      end else begin
         chk("in_ready_rule", {31'd0, bus.In_ready}, {31'd0, (bus.Out_ready || !bus.Out_valid)});
         if (bus.Out_valid) begin
            if (q.size() == 0)
               chk("unexpected_result", {31'd0, bus.Out_valid}, 32'd0);
            else
               chk("result", {12'd0, bus.Co, bus.V, bus.Z, bus.N, bus.S}, {12'd0, q[0]});
         end
      end
   end

   task automatic do_single(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic [1:0] op, input logic ci, input logic [19:0] exp);
      int lat;
      bus.A = a; bus.B = b; bus.Op = op; bus.Ci = ci;
      bus.In_valid = 1'b1; bus.Out_ready = 1'b1;
      @(negedge clk);
      bus.In_valid = 1'b0;
      bus.Op = ~op; bus.Ci = ~ci;
      lat = 1;
      while (!bus.Out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({name, "_latency"}, lat, 32'd4);
      chk({name, "_value"}, {12'd0, bus.Co, bus.V, bus.Z, bus.N, bus.S}, {12'd0, exp});
      chk({name, "_model"}, {12'd0, model(a, b, op, ci)}, {12'd0, exp});
   endtask

   initial begin
      int first, last, cnt, n0, j, stale;
      logic [15:0] held;

      bus.A = '0; bus.B = '0; bus.Op = 2'b00; bus.Ci = 1'b0;
      bus.In_valid = 1'b0; bus.Out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_state", {11'd0, bus.Out_valid, bus.Co, bus.V, bus.Z, bus.N, bus.S}, 32'd0);
      reset_n = 1'b1;
      #1;
      chk("ready_after_reset", {31'd0, bus.In_ready}, 32'd1);
      @(negedge clk);

      // {Co, V, Z, N, S}
      do_single("add_wrap",   16'hFFFF, 16'h0001, 2'b00, 1'b1, {1'b1, 1'b0, 1'b1, 1'b0, 16'h0000});
      do_single("add_ovf",    16'h7FFF, 16'h0001, 2'b00, 1'b0, {1'b0, 1'b1, 1'b0, 1'b1, 16'h8000});
      do_single("sub_borrow", 16'h0000, 16'h0001, 2'b01, 1'b0, {1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF});
      do_single("adc",        16'hFFFF, 16'h0000, 2'b10, 1'b1, {1'b1, 1'b0, 1'b1, 1'b0, 16'h0000});
      do_single("sbb",        16'h0005, 16'h0003, 2'b11, 1'b0, {1'b1, 1'b0, 1'b0, 1'b0, 16'h0001});
      repeat (2) @(negedge clk);

      // back-to-back stream
      n0 = n_out; first = -1; last = -1; cnt = 0;
      bus.Out_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (c < 25) begin
            bus.A = 16'(c * 20);
            bus.B = 16'(c * 17);
            bus.Op = (c % 2 == 1) ? 2'b01 : 2'b00;
            bus.Ci = 1'b1;
            bus.In_valid = 1'b1;
         end else begin
            bus.In_valid = 1'b0;
         end
         @(negedge clk);
         if (bus.Out_valid) begin
            cnt++;
            if (first < 0) first = c;
            last = c;
         end
      end
      chk("stream_count", cnt, 32'd25);
      chk("stream_contiguous", last - first, 32'd24);
      chk("stream_popped", n_out - n0, 32'd25);

      // backpressure: Out_ready low for 6 cycles mid-stream
      n0 = n_out; j = 0; held = '0;
      for (int c = 0; c < 50; c++) begin
         bus.Out_ready = !(c >= 10 && c < 16);
         if (j < 20) begin
            bus.A = 16'(j * 4369 + 7);
            bus.B = 16'(j * 3001);
            bus.Op = 2'(j % 4);
            bus.Ci = ((j / 2) % 2) == 1;
            bus.In_valid = 1'b1;
         end else begin
            bus.In_valid = 1'b0;
         end
         #1;
         if (c >= 10 && c < 16) begin
            if (c == 10) held = bus.S;
            else chk("stall_hold_s", {16'd0, bus.S}, {16'd0, held});
            chk("stall_out_valid", {31'd0, bus.Out_valid}, 32'd1);
            chk("stall_in_ready", {31'd0, bus.In_ready}, 32'd0);
         end
         if (bus.In_valid && bus.In_ready) j++;
         @(negedge clk);
      end
      chk("bp_accepted", j, 32'd20);
      chk("bp_results", n_out - n0, 32'd20);
      chk("bp_drain", q.size(), 32'd0);

      // reset with three operations in flight
      bus.Out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         bus.A = 16'(16'h1234 + c);
         bus.B = 16'h0101;
         bus.Op = 2'b00;
         bus.In_valid = 1'b1;
         @(negedge clk);
      end
      bus.In_valid = 1'b0;
      bus.Out_ready = 1'b0;
      @(negedge clk);
      chk("pre_reset_valid", {31'd0, bus.Out_valid}, 32'd1);
      chk("pre_reset_inflight", q.size(), 32'd3);
      reset_n = 1'b0;
      #1;
      chk("async_reset_valid", {31'd0, bus.Out_valid}, 32'd0);
      chk("async_reset_outputs", {12'd0, bus.Co, bus.V, bus.Z, bus.N, bus.S}, 32'd0);
      bus.Out_ready = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("release_ready", {31'd0, bus.In_ready}, 32'd1);
      stale = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.Out_valid) stale++;
      end
      chk("no_stale_result", stale, 32'd0);
      chk("final_drain", q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end
endmodule
`default_nettype wire

// File: doc/add_sub_pipe.md
ADD_SUB_PIPE -- requirements
Module: add_sub_pipe

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits.
REQ-002 Parameter CHUNK, default 4: bits resolved per pipeline stage; WIDTH SHALL be an integer multiple of CHUNK; STAGES = WIDTH/CHUNK.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 A  input  WIDTH  operand A.
REQ-006 B  input  WIDTH  operand B.
REQ-007 Op  input  2  operation: 00 add, 01 sub, 10 add-with-carry, 11 sub-with-borrow.
REQ-008 Ci  input  1  carry-in, used only by Op 10/11.
REQ-009 In_valid  input  1  A/B/Op/Ci valid this cycle.
REQ-010 In_ready  output  1  unit accepts the input this cycle.
REQ-011 S  output  WIDTH  result.
REQ-012 Co  output  1  carry-out of MSB; for subtraction 1 = no borrow.
REQ-013 V  output  1  signed two's-complement overflow.
REQ-014 Z  output  1  S equals zero.
REQ-015 N  output  1  S[WIDTH-1].
REQ-016 Out_valid  output  1  S and flags valid.
REQ-017 Out_ready  input  1  consumer accepts the result this cycle.

Function
REQ-018 Operation SHALL be S = A + B' + c0 with B' = B for Op 00/10 and ~B for Op 01/11; c0 = 0 for Op 00, 1 for Op 01, Ci for Op 10/11.
REQ-019 Carry chain SHALL be split into STAGES register stages of CHUNK bits each, LSB chunk first; each stage registers its partial sum, its carry, and the still-unprocessed operand bits.
REQ-020 A transfer in occurs when In_valid and In_ready are both 1; a transfer out occurs when Out_valid and Out_ready are both 1.
REQ-021 Latency SHALL be exactly STAGES cycles from input transfer to Out_valid, with no stall (4 cycles at defaults).
REQ-022 Pipeline SHALL advance when Out_ready = 1 or Out_valid = 0; In_ready SHALL equal this advance condition (combinational).
REQ-023 When not advancing, all stage registers, S, flags, and Out_valid SHALL hold; results SHALL neither be lost nor duplicated.
REQ-024 Throughput SHALL be one operation per cycle with Out_ready held at 1; empty slots (bubbles) SHALL propagate with valid = 0.
REQ-025 Co SHALL be the carry out of bit WIDTH-1.
REQ-026 V SHALL be 1 when A[MSB] equals B'[MSB] and S[MSB] differs from them.
REQ-027 Z, N, Co, V SHALL be registered together with S and SHALL change only when a new result enters the output stage.
REQ-028 Wrap-around: results SHALL be taken modulo 2^WIDTH, with no saturation.
REQ-029 Op and Ci SHALL be sampled at input transfer only; later changes SHALL NOT affect in-flight operations.

Reset
REQ-030 While reset_n = 0, all stage valid bits and Out_valid SHALL be 0, and S, Co, V, Z, N SHALL be 0, independent of clk.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight operations; no result from before reset SHALL appear after it.
REQ-032 After reset_n deasserts, In_ready SHALL be 1, and the first input transfer SHALL occur no earlier than the first rising clk edge with reset_n = 1.

Verification
REQ-033 Add, 0xFFFF + 0x0001, Out_ready = 1 -> 4 cycles later: S = 0x0000, Co = 1, Z = 1, V = 0, N = 0.
REQ-034 Add, 0x7FFF + 0x0001 -> S = 0x8000, V = 1, N = 1, Co = 0; sub, 0x0000 - 0x0001 -> S = 0xFFFF, Co = 0, V = 0, N = 1.
REQ-035 Chained ops: add-with-carry 0xFFFF + 0x0000 with Ci = 1 -> S = 0x0000, Co = 1; sub-with-borrow 0x0005 - 0x0003 with Ci = 0 -> S = 0x0001, Co = 1.
REQ-036 Back-to-back stream: for i = 0..24, A = i*20, B = i*17, alternating add/sub, Out_ready = 1 -> 25 in-order results, one per cycle, each matching a reference model.
REQ-037 Backpressure: Out_ready = 0 for 6 cycles while streaming -> In_ready = 0 once the pipe is full, S is held stable, and no result is lost or repeated after release.
REQ-038 reset_n pulsed low with 3 operations in flight -> Out_valid = 0 and all outputs = 0 immediately, with no stale result after release.
